bs_gnrtr_n_rbtr: RTL and testbench

BS_GNRTR_N_RBTR -- requirements
Module: bs_gnrtr_n_rbtr

---
 rtl/bs_gnrtr_n_rbtr.sv | 105 ++++++++++
 tb/tb_bs_gnrtr_n_rbtr.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bs_gnrtr_n_rbtr.sv
// rtl/bs_gnrtr_n_rbtr.sv - round-robin shared-bus arbiter: pop one source word, push it to its destination.
// Optional feature macro: BS_BROADCAST_EN (deliver broadcast-ID packets to every device except the source).
module bs_gnrtr_n_rbtr #(
  parameter int         bits      = 1,
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [bits-1:0][drvrs-1:0]             pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
  output logic [bits-1:0][drvrs-1:0]             pop,
  output logic [bits-1:0][drvrs-1:0]             push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);
  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, DELIVER} state_t;

  for (genvar b = 0; b < bits; b++) begin : g_bus
    state_t             r_state;
    logic [IW-1:0]      r_last;
    logic [IW-1:0]      r_win;
    logic [IW-1:0]      w_next;
    logic               w_any;
    logic [drvrs-1:0]   r_pop;
    logic [drvrs-1:0]   r_push;
    logic [drvrs-1:0]   w_mask;
    logic [pckg_sz-1:0] r_data;
    logic [pckg_sz-1:0] w_word;
    logic [7:0]         w_dest;

    // Round-robin search: first pending device after the last one actually popped.
    always_comb begin
      w_any  = 1'b0;
      w_next = r_last;
      for (int i = 1; i <= drvrs; i++) begin
        int j;
        j = (int'(r_last) + i) % drvrs;
        if (!w_any && pndng[b][j]) begin
          w_any  = 1'b1;
          w_next = IW'(j);
        end
      end
    end

    always_comb begin
      w_word = D_pop[b][r_win];
      w_dest = w_word[pckg_sz-1 -: 8];
      w_mask = '0;
      if (w_dest == broadcast) begin
`ifdef BS_BROADCAST_EN
        w_mask = ~(drvrs'(1) << r_win);
`endif
      end else if ((int'(w_dest) < drvrs) && (int'(w_dest) != int'(r_win))) begin
        w_mask = drvrs'(1) << w_dest;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= IDLE;
        r_last  <= IW'(drvrs - 1);
        r_win   <= '0;
        r_pop   <= '0;
        r_push  <= '0;
        r_data  <= '0;
      end else begin
        r_pop  <= '0;
        r_push <= '0;
        case (r_state)
          IDLE: begin
            if (w_any) begin
              r_win   <= w_next;
              r_pop   <= drvrs'(1) << w_next;
              r_state <= GRANT;
            end
          end
          GRANT: begin
            // A source that lost its pending flag is abandoned without touching last_grant.
            if (pndng[b][r_win]) begin
              r_data  <= w_word;
              r_last  <= r_win;
              r_push  <= w_mask;
              r_state <= DELIVER;
            end else begin
              r_state <= IDLE;
            end
          end
          DELIVER: r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end

    assign pop[b]  = r_pop & pndng[b];
    assign push[b] = r_push;

    for (genvar d = 0; d < drvrs; d++) begin : g_lane
      assign D_push[b][d] = r_data;
    end
  end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// tb/tb_bs_gnrtr_n_rbtr.sv - directed vector bench for bs_gnrtr_n_rbtr (drvrs=8, pckg_sz=16).
module tb_bs_gnrtr_n_rbtr;
  localparam int DR = 8;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [0:0][DR-1:0]         pndng;
  logic [0:0][DR-1:0][PW-1:0] D_pop;
  logic [0:0][DR-1:0]         pop;
  logic [0:0][DR-1:0]         push;
  logic [0:0][DR-1:0][PW-1:0] D_push;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          src;
    logic [15:0] word;
    logic [7:0]  exp_push;
  } vec_t;

  vec_t vecs[8];

  bs_gnrtr_n_rbtr #(.bits(1), .drvrs(DR), .pckg_sz(PW), .broadcast(8'hFF)) dut (
    .clk    (clk),
    .reset  (reset),
    .pndng  (pndng),
    .D_pop  (D_pop),
    .pop    (pop),
    .push   (push),
    .D_push (D_push)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_lanes(input string name, input logic [15:0] exp);
    for (int k = 0; k < DR; k++)
      check($sformatf("%s[%0d]", name, k), 32'(D_push[0][k]), 32'(exp));
  endtask

  initial begin
    int order[3];
    int ng;
    int last_cyc;
    int idx;

    vecs[0] = '{2, 16'h05AB, 8'h20};
    vecs[1] = '{4, 16'h0411, 8'h00};
    vecs[2] = '{4, 16'h0922, 8'h00};
`ifdef BS_BROADCAST_EN
    vecs[3] = '{1, 16'hFF33, 8'hFD};
`else
    vecs[3] = '{1, 16'hFF33, 8'h00};
`endif
    vecs[4] = '{0, 16'h0700, 8'h80};
    vecs[5] = '{7, 16'h00FE, 8'h01};
    vecs[6] = '{6, 16'h0855, 8'h00};
    vecs[7] = '{3, 16'h3A12, 8'h00};

    pndng = '0;
    D_pop = '0;

    // Reset held, then released with nothing pending.
    repeat (3) @(negedge clk);
    check("reset_pop", 32'(pop[0]), 32'h0);
    check("reset_push", 32'(push[0]), 32'h0);
    check("reset_dpush", 32'(D_push != '0), 32'h0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("idle_pop", 32'(pop[0]), 32'h0);
      check("idle_push", 32'(push[0]), 32'h0);
      check("idle_dpush", 32'(D_push != '0), 32'h0);
    end

    // Single-source transfers: valid, self, out-of-range, broadcast.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      pndng[0][vecs[v].src] = 1'b1;
      D_pop[0][vecs[v].src] = vecs[v].word;
      @(negedge clk);
      check($sformatf("vec%0d_pop", v), 32'(pop[0]), 32'(8'h01 << vecs[v].src));
      check($sformatf("vec%0d_push_early", v), 32'(push[0]), 32'h0);
      @(negedge clk);
      check($sformatf("vec%0d_push", v), 32'(push[0]), 32'(vecs[v].exp_push));
      check($sformatf("vec%0d_pop_after", v), 32'(pop[0]), 32'h0);
      if (vecs[v].exp_push != 8'h00) check_lanes($sformatf("vec%0d_dpush", v), vecs[v].word);
      pndng = '0;
      @(negedge clk);
      check($sformatf("vec%0d_push_end", v), 32'(push[0]), 32'h0);
    end

    // Pending drop during GRANT aborts with no pop; last_grant must stay put.
    @(negedge clk);
    pndng[0][5] = 1'b1;
    D_pop[0][5] = 16'h0001;
    @(negedge clk);
    pndng = '0;
    #1;
    check("abort_pop", 32'(pop[0]), 32'h0);
    @(negedge clk);
    check("abort_push", 32'(push[0]), 32'h0);
    pndng[0][5] = 1'b1;
    pndng[0][6] = 1'b1;
    D_pop[0][6] = 16'h0002;
    @(negedge clk);
    check("abort_regrant", 32'(pop[0]), 32'h20);
    @(negedge clk);
    check("abort_push2", 32'(push[0]), 32'h01);
    check_lanes("abort_dpush", 16'h0001);
    pndng = '0;

    // Reset asserted during DELIVER kills the push at once.
    @(negedge clk);
    pndng[0][2] = 1'b1;
    D_pop[0][2] = 16'h05AB;
    @(negedge clk);
    check("midop_pop", 32'(pop[0]), 32'h04);
    @(negedge clk);
    check("midop_push_before", 32'(push[0]), 32'h20);
    pndng = '0;
    #1 reset = 1'b1;
    #1;
    check("midop_push_async", 32'(push[0]), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("midop_no_push", 32'(push[0]), 32'h0);
      check("midop_no_pop", 32'(pop[0]), 32'h0);
    end

    // Three held requesters: rotating 0,3,7 with one grant every 3 cycles.
    order[0] = 0; order[1] = 3; order[2] = 7;
    ng = 0;
    last_cyc = 0;
    @(negedge clk);
    D_pop[0][0] = 16'h0311;
    D_pop[0][3] = 16'h0722;
    D_pop[0][7] = 16'h0033;
    pndng[0][0] = 1'b1;
    pndng[0][3] = 1'b1;
    pndng[0][7] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      check("arb_onehot", 32'($countones(pop[0]) <= 1), 32'h1);
      check("arb_pop_pending", 32'(pop[0] & ~pndng[0]), 32'h0);
      if (pop[0] != '0) begin
        idx = -1;
        for (int k = 0; k < DR; k++) if (pop[0][k]) idx = k;
        check($sformatf("arb_order%0d", ng), 32'(idx), 32'(order[ng % 3]));
        if (ng > 0) check($sformatf("arb_spacing%0d", ng), 32'(c - last_cyc), 32'h3);
        last_cyc = c;
        ng++;
      end
    end
    check("arb_grants", 32'(ng >= 9), 32'h1);
    pndng = '0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
